// File: rtl/addsub_serial.sv
// Chunk-serial two's-complement adder/subtractor: CHUNK bits per cycle, carry held between chunks.
// Optional macro ADDSUB_SATURATE_EN clamps the result to max/min on signed overflow.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl,
  output logic             Cout,
  output logic             Zero,
  output logic             Neg
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CHUNK-1:0] CMASK = {CHUNK{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, a_sh, b_sh, sum_nx, sum_fin;
  logic [CHUNK-1:0] a_c, b_c, s_c;
  logic [CW-1:0]    cnt;
  logic             carry, c_o, c_msb_in, ovfl_nx, accept, last;
  int               sh;

  always_comb begin
    state_nx  = state;
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    accept    = in_valid && in_ready;
    out_valid = (state == DONE);
    last      = (cnt == CW'(N - 1));
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (accept) state_nx = BUSY;
               else if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One chunk slice; the carry into the top bit is recovered from its sum bit.
  always_comb begin
    sh         = int'(cnt) * CHUNK;
    a_sh       = a_q >> sh;
    b_sh       = b_q >> sh;
    a_c        = a_sh[CHUNK-1:0];
    b_c        = b_sh[CHUNK-1:0];
    {c_o, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
    sum_nx     = (Sum & ~(WIDTH'(CMASK) << sh)) | (WIDTH'(s_c) << sh);
    c_msb_in   = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ s_c[CHUNK-1];
    ovfl_nx    = c_msb_in ^ c_o;
    sum_fin    = sum_nx;
`ifdef ADDSUB_SATURATE_EN
    if (ovfl_nx)
      sum_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      Sum   <= '0;
      Ovfl  <= 1'b0;
      Cout  <= 1'b0;
      Zero  <= 1'b0;
      Neg   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q   <= A;
        b_q   <= B ^ {WIDTH{sub}};
        carry <= sub;
        cnt   <= '0;
      end else if (state == BUSY) begin
        carry <= c_o;
        cnt   <= cnt + 1'b1;
        if (last) begin
          Sum  <= sum_fin;
          Cout <= c_o;
          Ovfl <= ovfl_nx;
          Zero <= (sum_fin == '0);
          Neg  <= sum_fin[WIDTH-1];
        end else begin
          Sum <= sum_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial (WIDTH=16, CHUNK=4): results, flags, latency, backpressure, reset.
module tb_addsub_serial;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, sub = 1'b0, out_valid, out_ready = 1'b0;
  logic [15:0] A = '0, B = '0, Sum;
  logic        Ovfl, Cout, Zero, Neg;
  int          tests = 0, fails = 0;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Ovfl(Ovfl), .Cout(Cout), .Zero(Zero), .Neg(Neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present an operation, wait (bounded) for acceptance, then drop in_valid.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    int i;
    A = a; B = b; sub = s; in_valid = 1'b1;
    for (i = 0; i < 20 && !in_ready; i++) step();
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    chk({tag, "_latency"}, lat, 32'd4);
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                     input logic [15:0] esum, input logic eovf, input logic ecout,
                     input logic ezero, input logic eneg);
    send(a, b, s);
    wait_out(tag);
    chk({tag, "_sum"}, {16'b0, Sum}, {16'b0, esum});
    chk({tag, "_flags"}, {28'b0, Ovfl, Cout, Zero, Neg}, {28'b0, eovf, ecout, ezero, eneg});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    step(); step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", {16'b0, Sum}, 32'd0);
    chk("rst_flags", {28'b0, Ovfl, Cout, Zero, Neg}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    run("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SATURATE_EN
    run("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
    run("neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    run("sub_min", 16'h0001, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    run("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    run("neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run("sub_min", 16'h0001, 16'h8000, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    run("eq_sub", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run("zero_sub", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run("wrap_add", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run("mix_sub", 16'h1000, 16'h2345, 1'b1, 16'hECBB, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held in DONE, then back-to-back accept.
    send(16'h00F0, 16'h0F0F, 1'b0);
    wait_out("bp");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_sum", {16'b0, Sum}, 32'h0FFF);
      chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    A = 16'h0001; B = 16'h0001; sub = 1'b0; in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_busy", {31'b0, out_valid}, 32'd0);
    wait_out("b2b");
    chk("b2b_sum", {16'b0, Sum}, 32'h0002);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during BUSY abandons the operation.
    send(16'h1111, 16'h2222, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_sum", {16'b0, Sum}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) seen++;
    end
    chk("mid_rst_no_stale", seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
